// File: rtl/hex_scan_driver.sv
// Time-multiplexed NUM_DIGITS x 7-seg driver (common anode, active-low segments) with a load-latched shadow word.
// Latency: all outputs are registered; load reaches the display at the next scan tick; first tick is SCAN_DIV cycles after reset.
// Backpressure: none; load is a one-cycle strobe that is always accepted. Optional HEX_SCAN_LZB_EN adds leading-zero blanking.
module hex_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int CNT_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_data,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    scan_tick
);

    localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = 7'h7F;

    logic [CNT_W-1:0]          presc_q, presc_d;
    logic [IDX_W-1:0]          idx_q, idx_d, idx_nxt;
    logic [4*NUM_DIGITS-1:0]   shadow_hex_q, shadow_hex_d;
    logic [NUM_DIGITS-1:0]     shadow_mask_q, shadow_mask_d;
    logic [6:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     dig_q, dig_d;
    logic                      tick_q, tick_d;
    logic                      scan_hit;
    logic [NUM_DIGITS-1:0]     lzb;
    logic [3:0]                nib [NUM_DIGITS];

    // Active-low segment pattern, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign nib[g] = shadow_hex_q[4*g +: 4];
    end

`ifdef HEX_SCAN_LZB_EN
    // A digit goes dark when it and every more-significant shadow nibble are zero; digit 0 always shows.
    always_comb begin : lzb_calc
        logic zero_run;
        lzb      = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (nib[k] == 4'h0);
            lzb[k]   = zero_run;
        end
    end
`else
    assign lzb = '0;
`endif

    // Next state: prescaler wrap drives the digit advance; the segment value uses the pre-load shadow.
    always_comb begin
        scan_hit      = (presc_q == LAST_CNT);
        idx_nxt       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        presc_d       = scan_hit ? '0 : presc_q + 1'b1;
        idx_d         = scan_hit ? idx_nxt : idx_q;
        shadow_hex_d  = load ? hex_data   : shadow_hex_q;
        shadow_mask_d = load ? blank_mask : shadow_mask_q;
        tick_d        = scan_hit;
        seg_d         = seg_q;
        dig_d         = dig_q;
        if (scan_hit) begin
            dig_d          = '0;
            dig_d[idx_nxt] = 1'b1;
            seg_d          = (shadow_mask_q[idx_nxt] | lzb[idx_nxt]) ? SEG_OFF : hex_to_seg(nib[idx_nxt]);
        end
    end

    // State and output registers; reset leaves everything dark with the index parked on the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= LAST_IDX;
            shadow_hex_q  <= '0;
            shadow_mask_q <= '1;
            seg_q         <= SEG_OFF;
            dig_q         <= '0;
            tick_q        <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            shadow_hex_q  <= shadow_hex_d;
            shadow_mask_q <= shadow_mask_d;
            seg_q         <= seg_d;
            dig_q         <= dig_d;
            tick_q        <= tick_d;
        end
    end

    assign seg_data  = seg_q;
    assign dig_sel   = dig_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver with 4 digits and a 4-cycle slot.
// Directed vector table, hand sequences for leading zeros / sweep / mid-scan reset, then random traffic vs a cycle-count model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after it.
module tb_hex_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int CW = 4;
`ifdef HEX_SCAN_LZB_EN
    localparam logic [6:0] LZ = 7'h7F;
    localparam bit LZB_ON = 1'b1;
`else
    localparam logic [6:0] LZ = 7'h40;
    localparam bit LZB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] hex_data = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [6:0]  seg_data;
    logic [3:0]  dig_sel;
    logic        scan_tick;

    int errors = 0;
    int checks = 0;

    hex_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .hex_data   (hex_data),
        .blank_mask (blank_mask),
        .seg_data   (seg_data),
        .dig_sel    (dig_sel),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: edges counted since reset release; tick on every SD-th edge, digit = (tick number - 1) mod ND.
    int          m_edges;
    logic [15:0] m_hex;
    logic [3:0]  m_mask;
    logic [6:0]  m_seg;
    logic [3:0]  m_dig;
    logic        m_tick;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit dark(input int d);
        bit lead_zero;
        lead_zero = LZB_ON && (d > 0) && ((m_hex >> (4 * d)) == 16'h0);
        return m_mask[d] || lead_zero;
    endfunction

    task automatic model_reset();
        m_edges = 0;
        m_hex   = 16'h0;
        m_mask  = 4'hF;
        m_seg   = 7'h7F;
        m_dig   = 4'h0;
        m_tick  = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [15:0] hx, input logic [3:0] mk);
        int d;
        load       = ld;
        hex_data   = hx;
        blank_mask = mk;
        @(posedge clk);
        m_edges++;
        m_tick = ((m_edges % SD) == 0);
        if (m_tick) begin
            d     = ((m_edges / SD) - 1) % ND;
            m_dig = 4'(1 << d);
            m_seg = dark(d) ? 7'h7F : dec_tbl[m_hex[4*d +: 4]];
        end
        if (ld) begin
            m_hex  = hx;
            m_mask = mk;
        end
        #1;
        chk("model seg_data", {1'b0, seg_data}, {1'b0, m_seg});
        chk("model dig_sel", {4'h0, dig_sel}, {4'h0, m_dig});
        chk("model scan_tick", {7'h0, scan_tick}, {7'h0, m_tick});
        load = 1'b0;
    endtask

    // Asserts reset away from the edge, checks the immediate effect, releases 1 unit after an edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset seg_data", {1'b0, seg_data}, 8'h7F);
        chk("reset dig_sel", {4'h0, dig_sel}, 8'h00);
        chk("reset scan_tick", {7'h0, scan_tick}, 8'h00);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, hex_data, blank_mask);
    endtask

    task automatic expect_out(input string name, input logic [6:0] s, input logic [3:0] dg, input logic tk);
        chk({name, " seg_data"}, {1'b0, seg_data}, {1'b0, s});
        chk({name, " dig_sel"}, {4'h0, dig_sel}, {4'h0, dg});
        chk({name, " scan_tick"}, {7'h0, scan_tick}, {7'h0, tk});
    endtask

    typedef struct {
        int          n;
        logic        ld;
        logic [15:0] hex;
        logic [3:0]  mask;
        logic [6:0]  seg;
        logic [3:0]  dig;
        logic        tick;
    } vec_t;

    vec_t vt [18];

    initial begin
        // n edges per row, load only on the first edge of the row, outputs checked after the last edge.
        vt[0]  = '{3, 1'b0, 16'h0000, 4'h0, 7'h7F, 4'b0000, 1'b0};
        vt[1]  = '{1, 1'b0, 16'h0000, 4'h0, 7'h7F, 4'b0001, 1'b1};
        vt[2]  = '{1, 1'b1, 16'h8F1A, 4'h0, 7'h7F, 4'b0001, 1'b0};
        vt[3]  = '{3, 1'b0, 16'h8F1A, 4'h0, 7'h79, 4'b0010, 1'b1};
        vt[4]  = '{4, 1'b0, 16'h8F1A, 4'h0, 7'h0E, 4'b0100, 1'b1};
        vt[5]  = '{4, 1'b0, 16'h8F1A, 4'h0, 7'h00, 4'b1000, 1'b1};
        vt[6]  = '{2, 1'b0, 16'h8F1A, 4'h0, 7'h00, 4'b1000, 1'b0};
        vt[7]  = '{2, 1'b0, 16'h8F1A, 4'h0, 7'h08, 4'b0001, 1'b1};
        vt[8]  = '{1, 1'b1, 16'h0000, 4'h0, 7'h08, 4'b0001, 1'b0};
        vt[9]  = '{2, 1'b0, 16'h0000, 4'h0, 7'h08, 4'b0001, 1'b0};
        vt[10] = '{1, 1'b1, 16'h1111, 4'h0, LZ,    4'b0010, 1'b1};
        vt[11] = '{4, 1'b0, 16'h1111, 4'h0, 7'h79, 4'b0100, 1'b1};
        vt[12] = '{1, 1'b1, 16'h1234, 4'h4, 7'h79, 4'b0100, 1'b0};
        vt[13] = '{3, 1'b0, 16'h1234, 4'h4, 7'h79, 4'b1000, 1'b1};
        vt[14] = '{4, 1'b0, 16'h1234, 4'h4, 7'h19, 4'b0001, 1'b1};
        vt[15] = '{4, 1'b0, 16'h1234, 4'h4, 7'h30, 4'b0010, 1'b1};
        vt[16] = '{4, 1'b0, 16'h1234, 4'h4, 7'h7F, 4'b0100, 1'b1};
        vt[17] = '{4, 1'b0, 16'h1234, 4'h4, 7'h79, 4'b1000, 1'b1};

        model_reset();
        do_reset();

        for (int i = 0; i < 18; i++) begin
            for (int j = 0; j < vt[i].n; j++) step((j == 0) ? vt[i].ld : 1'b0, vt[i].hex, vt[i].mask);
            expect_out($sformatf("vec%0d", i), vt[i].seg, vt[i].dig, vt[i].tick);
        end

        // Leading zeros: 0x0030 loaded at edge 49, slots at edges 52/56/60/64.
        step(1'b1, 16'h0030, 4'h0);
        run(3);
        expect_out("lzb d0", 7'h40, 4'b0001, 1'b1);
        run(4);
        expect_out("lzb d1", 7'h30, 4'b0010, 1'b1);
        run(4);
        expect_out("lzb d2", LZ, 4'b0100, 1'b1);
        run(4);
        expect_out("lzb d3", LZ, 4'b1000, 1'b1);

        // Every nibble value through digit 0, one per 16-cycle refresh.
        for (int v = 0; v < 16; v++) begin
            step(1'b1, {12'hC50, 4'(v)}, 4'h0);
            run(3);
            expect_out($sformatf("sweep %0h", v), dec_tbl[v], 4'b0001, 1'b1);
            run(12);
        end

        // Reset in the middle of a refresh, then the scan restarts from digit 0 after a full slot.
        run(6);
        do_reset();
        run(3);
        expect_out("restart idle", 7'h7F, 4'b0000, 1'b0);
        run(1);
        expect_out("restart d0", 7'h7F, 4'b0001, 1'b1);

        // Random traffic against the model, with an occasional mid-scan reset.
        for (int i = 0; i < 800; i++) begin
            logic [15:0] hx;
            logic [3:0]  mk;
            hx = 16'($urandom) >> (4 * $urandom_range(0, 4));
            mk = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 5) == 0, hx, mk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
